// File: rtl/ram_sp_param.sv
// ram_sp_param: parametrised single-port synchronous RAM with byte-lane writes,
// selectable read-during-write behaviour, a registered read with valid strobe
// and a clear engine that writes CLEAR_VALUE to every word after reset or on
// request.
//
// Optional feature macro: RAM_PARITY_EN
//   When defined, each stored word carries one even-parity bit per byte lane
//   and the extra output parity_error flags a lane mismatch on any valid read.
//
// Ports:
//   clk           in   clock, rising edge
//   reset         in   synchronous active-high reset
//   clear_req     in   one-cycle pulse, starts a full clear when idle
//   en            in   access request
//   write_enable  in   1 = write, 0 = read (qualified by en)
//   byte_en       in   per-byte write lane enable
//   address       in   word address
//   data_in       in   write data
//   data_out      out  registered read data
//   data_valid    out  one-cycle strobe, data_out updated by an access
//   busy          out  clear engine active, accesses ignored
//   parity_error  out  (RAM_PARITY_EN only) lane parity mismatch on a read
module ram_sp_param #(
    parameter int unsigned           DATA_WIDTH  = 16,
    parameter int unsigned           ADDR_WIDTH  = 10,
    parameter int unsigned           RDW_MODE    = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear_req,
    input  logic                    en,
    input  logic                    write_enable,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    data_valid,
    output logic                    busy
`ifdef RAM_PARITY_EN
    ,
    output logic                    parity_error
`endif
);

    localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
    localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
`ifdef RAM_PARITY_EN
    localparam int unsigned PAR_W     = NUM_BYTES;
`else
    localparam int unsigned PAR_W     = 0;
`endif
    localparam int unsigned ENTRY_W   = DATA_WIDTH + PAR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

`ifdef RAM_PARITY_EN
    // Even parity per byte lane.
    function automatic logic [NUM_BYTES-1:0] f_parity(input logic [DATA_WIDTH-1:0] d);
        logic [NUM_BYTES-1:0] p;
        for (int i = 0; i < int'(NUM_BYTES); i++) begin
            p[i] = ^d[8*i +: 8];
        end
        return p;
    endfunction
`endif

    // Storage word for a given data word (parity appended above the data).
    function automatic logic [ENTRY_W-1:0] f_encode(input logic [DATA_WIDTH-1:0] d);
`ifdef RAM_PARITY_EN
        return {f_parity(d), d};
`else
        return d;
`endif
    endfunction

    logic [ENTRY_W-1:0]    r_mem [DEPTH];
    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] w_ptr_nxt;
    logic                  w_busy_nxt;
    logic [DATA_WIDTH-1:0] w_dout_nxt;
    logic                  w_valid_nxt;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [ENTRY_W-1:0]    w_mem_wdata;
    logic [ENTRY_W-1:0]    w_old_entry;
    logic [ENTRY_W-1:0]    w_merged_entry;
`ifdef RAM_PARITY_EN
    logic [ENTRY_W-1:0]    w_chk_entry;
    logic                  w_par_err_nxt;
`endif

    assign w_old_entry = r_mem[address];

    // Byte-lane merge of write data into the currently stored entry.
    always_comb begin
        w_merged_entry = w_old_entry;
        for (int i = 0; i < int'(NUM_BYTES); i++) begin
            if (byte_en[i]) begin
                w_merged_entry[8*i +: 8] = data_in[8*i +: 8];
`ifdef RAM_PARITY_EN
                w_merged_entry[DATA_WIDTH + i] = ^data_in[8*i +: 8];
`endif
            end
        end
    end

    // Next-state, memory write port and next output values.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_busy_nxt  = busy;
        w_dout_nxt  = data_out;
        w_valid_nxt = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = address;
        w_mem_wdata = w_merged_entry;
`ifdef RAM_PARITY_EN
        w_chk_entry = w_old_entry;
`endif
        case (r_state)
            ST_CLEAR: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_ptr;
                w_mem_wdata = f_encode(CLEAR_VALUE);
                w_ptr_nxt   = r_ptr + ADDR_WIDTH'(1);
                if (r_ptr == ADDR_WIDTH'(DEPTH - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                end
            end
            ST_IDLE: begin
                // A clear request wins over a simultaneous access.
                if (clear_req) begin
                    w_state_nxt = ST_CLEAR;
                    w_ptr_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                end else if (en) begin
                    if (write_enable) begin
                        w_mem_we = 1'b1;
                        if (RDW_MODE == 0) begin
                            w_dout_nxt  = w_old_entry[DATA_WIDTH-1:0];
                            w_valid_nxt = 1'b1;
                        end else if (RDW_MODE == 1) begin
                            w_dout_nxt  = w_merged_entry[DATA_WIDTH-1:0];
                            w_valid_nxt = 1'b1;
`ifdef RAM_PARITY_EN
                            w_chk_entry = w_merged_entry;
`endif
                        end
                    end else begin
                        w_dout_nxt  = w_old_entry[DATA_WIDTH-1:0];
                        w_valid_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_ptr_nxt   = '0;
                w_busy_nxt  = 1'b1;
            end
        endcase
`ifdef RAM_PARITY_EN
        w_par_err_nxt = w_valid_nxt &&
            (w_chk_entry[ENTRY_W-1:DATA_WIDTH] != f_parity(w_chk_entry[DATA_WIDTH-1:0]));
`endif
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_CLEAR;
            r_ptr        <= '0;
            busy         <= 1'b1;
            data_out     <= '0;
            data_valid   <= 1'b0;
`ifdef RAM_PARITY_EN
            parity_error <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            busy         <= w_busy_nxt;
            data_out     <= w_dout_nxt;
            data_valid   <= w_valid_nxt;
`ifdef RAM_PARITY_EN
            parity_error <= w_par_err_nxt;
`endif
        end
    end

    // Storage array; reset leaves the contents alone.
    always_ff @(posedge clk) begin
        if (w_mem_we && !reset) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

endmodule

// File: tb/tb_ram_sp_param.sv
module tb_ram_sp_param;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;
    localparam logic [15:0] CV    = 16'hA5A5;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear_req;
    logic        en;
    logic        write_enable;
    logic [1:0]  byte_en;
    logic [3:0]  address;
    logic [15:0] data_in;

    // Index 0 = read-first, 1 = write-first, 2 = no-change.
    logic [15:0] dout  [3];
    logic        valid [3];
    logic        busy  [3];
`ifdef RAM_PARITY_EN
    logic        perr  [3];
`endif

    always #5 clk = ~clk;

    ram_sp_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(0), .CLEAR_VALUE(CV)) u_rf (
        .clk(clk), .reset(reset), .clear_req(clear_req), .en(en),
        .write_enable(write_enable), .byte_en(byte_en), .address(address),
        .data_in(data_in), .data_out(dout[0]), .data_valid(valid[0]), .busy(busy[0])
`ifdef RAM_PARITY_EN
        , .parity_error(perr[0])
`endif
    );
    ram_sp_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(1), .CLEAR_VALUE(CV)) u_wf (
        .clk(clk), .reset(reset), .clear_req(clear_req), .en(en),
        .write_enable(write_enable), .byte_en(byte_en), .address(address),
        .data_in(data_in), .data_out(dout[1]), .data_valid(valid[1]), .busy(busy[1])
`ifdef RAM_PARITY_EN
        , .parity_error(perr[1])
`endif
    );
    ram_sp_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(2), .CLEAR_VALUE(CV)) u_nc (
        .clk(clk), .reset(reset), .clear_req(clear_req), .en(en),
        .write_enable(write_enable), .byte_en(byte_en), .address(address),
        .data_in(data_in), .data_out(dout[2]), .data_valid(valid[2]), .busy(busy[2])
`ifdef RAM_PARITY_EN
        , .parity_error(perr[2])
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    endtask

    // Behavioural reference: word array plus a count of remaining clear cycles.
    logic [15:0] m_mem [16];
    logic [15:0] exp_dout  [3];
    logic        exp_valid [3];
    logic        exp_busy;
    int          busy_left   = 0;
    int          clr_ptr     = 0;
    bit          model_ready = 0;
    bit          flip_done   = 0;

    always @(posedge clk) begin
        logic [15:0] old_w, new_w;
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                exp_dout[k]  = '0;
                exp_valid[k] = 1'b0;
            end
            busy_left   = DEPTH;
            clr_ptr     = 0;
            exp_busy    = 1'b1;
            model_ready = 1;
        end else if (model_ready) begin
            for (int k = 0; k < 3; k++) exp_valid[k] = 1'b0;
            if (busy_left > 0) begin
                m_mem[clr_ptr] = CV;
                clr_ptr++;
                busy_left--;
                exp_busy = (busy_left != 0);
            end else if (clear_req) begin
                busy_left = DEPTH;
                clr_ptr   = 0;
                exp_busy  = 1'b1;
            end else if (en) begin
                old_w = m_mem[address];
                if (write_enable) begin
                    new_w = old_w;
                    if (byte_en[0]) new_w[7:0]  = data_in[7:0];
                    if (byte_en[1]) new_w[15:8] = data_in[15:8];
                    m_mem[address] = new_w;
                    exp_dout[0] = old_w; exp_valid[0] = 1'b1;
                    exp_dout[1] = new_w; exp_valid[1] = 1'b1;
                end else begin
                    for (int k = 0; k < 3; k++) begin
                        exp_dout[k]  = old_w;
                        exp_valid[k] = 1'b1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_ready) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("busy[%0d]", k), 32'(busy[k]), 32'(exp_busy));
                chk($sformatf("valid[%0d]", k), 32'(valid[k]), 32'(exp_valid[k]));
                chk($sformatf("dout[%0d]", k), 32'(dout[k]), 32'(exp_dout[k]));
`ifdef RAM_PARITY_EN
                if (!flip_done) chk($sformatf("perr[%0d]", k), 32'(perr[k]), 32'(0));
`endif
            end
        end
    end

    // Apply one cycle of inputs; returns just after the consuming edge.
    task automatic cyc(input logic r, input logic cr, input logic e, input logic we,
                       input logic [1:0] be, input logic [3:0] a, input logic [15:0] d);
        reset = r; clear_req = cr; en = e; write_enable = we;
        byte_en = be; address = a; data_in = d;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 2'b00, 4'd0, 16'h0);
    endtask

    task automatic rd(input logic [3:0] a);
        cyc(0, 0, 1, 0, 2'b00, a, 16'h0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
        cyc(0, 0, 1, 1, be, a, d);
    endtask

    // Count edges until busy drops, optionally poking accesses/clear requests.
    task automatic count_busy(output int n, input bit poke);
        n = 0;
        while (busy[0] && n < 40) begin
            if (poke) cyc(0, ($urandom_range(0, 3) == 0), 1'b1, 1'($urandom),
                          2'($urandom), 4'($urandom), 16'($urandom));
            else idle();
            n++;
        end
    endtask

    initial begin
        int n;
        reset = 1'b1; clear_req = 1'b0; en = 1'b0; write_enable = 1'b0;
        byte_en = '0; address = '0; data_in = '0;
        @(posedge clk); #2;
        cyc(1, 0, 0, 0, 2'b00, 4'd0, 16'h0);
        chk("reset_busy", 32'(busy[0]), 32'(1));
        chk("reset_dout", 32'(dout[0]), 32'(0));
        chk("reset_valid", 32'(valid[0]), 32'(0));

        count_busy(n, 0);
        chk("init_clear_cycles", 32'(n), 32'(16));

        for (int i = 0; i < 16; i++) begin
            rd(4'(i));
            chk("clear_read_data", 32'(dout[0]), 32'(CV));
            chk("clear_read_valid", 32'(valid[0]), 32'(1));
        end

        wr(4'd5, 16'h1234, 2'b11);
        rd(4'd5);
        chk("full_write", 32'(dout[0]), 32'h1234);
        wr(4'd5, 16'hFF00, 2'b01);
        rd(4'd5);
        chk("lane_write", 32'(dout[0]), 32'h1200);

        wr(4'd5, 16'h1234, 2'b11);
        wr(4'd5, 16'hBEEF, 2'b11);
        chk("rdw_read_first", 32'(dout[0]), 32'h1234);
        chk("rdw_write_first", 32'(dout[1]), 32'hBEEF);
        chk("rdw_no_change_data", 32'(dout[2]), 32'h1200);
        chk("rdw_no_change_valid", 32'(valid[2]), 32'(0));

        wr(4'd5, 16'h0000, 2'b00);
        rd(4'd5);
        chk("noop_write", 32'(dout[0]), 32'hBEEF);

        cyc(0, 1, 1, 1, 2'b11, 4'd7, 16'hDEAD);
        chk("clear_req_busy", 32'(busy[0]), 32'(1));
        count_busy(n, 1);
        chk("req_clear_cycles", 32'(n), 32'(16));
        rd(4'd7);
        chk("dropped_write", 32'(dout[0]), 32'(CV));
        rd(4'd5);
        chk("cleared_word", 32'(dout[0]), 32'(CV));

        wr(4'd2, 16'h5A5A, 2'b11);
        cyc(0, 1, 0, 0, 2'b00, 4'd0, 16'h0);
        for (int i = 0; i < 6; i++) idle();
        cyc(1, 0, 0, 0, 2'b00, 4'd0, 16'h0);
        chk("midclear_reset_dout", 32'(dout[0]), 32'(0));
        count_busy(n, 1);
        chk("restart_clear_cycles", 32'(n), 32'(16));

        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 199) == 0),
                ($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom),
                4'($urandom), 16'($urandom));
        end
        count_busy(n, 0);
        chk("random_tail_idle", 32'(busy[0]), 32'(0));

`ifdef RAM_PARITY_EN
        idle();
        flip_done = 1;
        u_rf.r_mem[3][16] = ~u_rf.r_mem[3][16];
        rd(4'd3);
        chk("parity_flip", 32'(perr[0]), 32'(1));
        idle();
        chk("parity_pulse", 32'(perr[0]), 32'(0));
        rd(4'd4);
        chk("parity_clean", 32'(perr[0]), 32'(0));
`endif
        idle();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ram_sp_param.md
Name: ram_sp_param

Overview:
- Parametrised successor to the team's fixed 1024x8 single-port RAM.
- Single-port synchronous RAM with:
  - configurable width and depth
  - byte-lane write enables
  - selectable read-during-write mode
  - registered read with a valid strobe
  - a hardware clear engine that initialises every location after reset or on request
- Used as the generic on-chip buffer memory for datapath blocks.

Parameters:
- DATA_WIDTH, 16, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 10, address width; DEPTH = 2**ADDR_WIDTH words.
- RDW_MODE, 0, read-during-write: 0 = read-first (old word), 1 = write-first (new merged word), 2 = no-change.
- CLEAR_VALUE, 0, DATA_WIDTH-bit value written to every location by the clear engine.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- clear_req  input  1  one-cycle pulse; starts a full clear when idle.
- en  input  1  access request.
- write_enable  input  1  1 = write, 0 = read; qualified by en.
- byte_en  input  DATA_WIDTH/8  per-byte write lane enable; bit i covers data_in[8i+7:8i].
- address  input  ADDR_WIDTH  word address.
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  registered read data.
- data_valid  output  1  high for one cycle when data_out was updated by an access.
- busy  output  1  clear engine active; accesses ignored.

Behaviour:
- Reset
  - Reset sampled high at edge k: data_out=0, data_valid=0, busy=1, clear pointer=0, state=CLEAR.
  - Memory contents are not touched by reset itself.
- States
  - CLEAR:
    - Each edge with reset low writes CLEAR_VALUE to mem[ptr], then increments ptr.
    - The edge that writes ptr==DEPTH-1 moves the state to IDLE and sets busy=0.
    - After reset deasserts, exactly DEPTH cycles elapse with busy=1.
  - IDLE:
    - Serves accesses.
    - clear_req=1 at an edge: state=CLEAR, ptr=0, busy=1 from the next cycle.
    - clear_req takes priority over a simultaneous en; that access is dropped.
- Accesses during CLEAR
  - en is ignored: no memory write, data_out holds, data_valid=0.
  - clear_req during CLEAR is ignored; the clear does not restart.
- Reset mid-clear: the clear restarts from address 0 and runs a full DEPTH cycles.
- Read (IDLE, en=1, write_enable=0)
  - data_out = mem[address] after the same edge; 1-cycle latency.
  - data_valid=1 for that cycle.
- Write (IDLE, en=1, write_enable=1)
  - Only lanes with byte_en[i]=1 are updated; other lanes keep their old bytes.
  - byte_en=0 is a legal no-op write.
  - RDW_MODE=0: data_out = old word, data_valid=1.
  - RDW_MODE=1: data_out = merged new word, data_valid=1.
  - RDW_MODE=2: data_out holds, data_valid=0.
- Idle cycles (en=0): data_out holds its last value, data_valid=0.
- Addressing: address covers the full DEPTH exactly; there is no out-of-range case. The clear pointer wraps only at state exit.
- Back-to-back accesses are allowed every cycle with no bubbles.

Optional Feature:
- Macro RAM_PARITY_EN.
- Defined:
  - The array stores one extra even-parity bit per byte lane, computed on write and on clear.
  - On every read whose data_valid is 1, parity is recomputed.
  - Added output parity_error (1 bit): registered alongside data_out, pulses for one cycle on any lane mismatch, reset 0.
- Not defined: no parity storage and no parity_error port; the array is exactly DATA_WIDTH wide.

Test Plan (DATA_WIDTH=16, ADDR_WIDTH=4, CLEAR_VALUE=16'hA5A5):
- Reset 2 cycles, then release -> busy=1 for exactly 16 cycles then 0; reads of addresses 0..15 all return 16'hA5A5 with data_valid=1 one cycle after each request.
- Write 16'h1234 to address 5 with byte_en=2'b11, then read 5 -> data_out=16'h1234 next cycle. Write 16'hFF00 to address 5 with byte_en=2'b01, then read 5 -> 16'h1200.
- RDW_MODE=0: write 16'hBEEF to an address holding 16'h1234 -> data_out=16'h1234. RDW_MODE=1 -> data_out=16'hBEEF. RDW_MODE=2 -> data_out unchanged and data_valid=0.
- clear_req and a write (en=1) in the same cycle -> write dropped, busy=1 for 16 cycles; read of the written address returns 16'hA5A5.
- Reset asserted at clear cycle 7 -> clear restarts: busy stays high for 16 cycles after reset release. Reads issued during busy produce data_valid=0 and data_out unchanged.
- RAM_PARITY_EN defined: force-flip one stored bit at address 3 via hierarchical reference, then read 3 -> parity_error=1 for one cycle. Read of a clean address -> parity_error=0.
